// File: rtl/rvh_l1d_mshr_dealloc.sv
// MSHR lifecycle tracker (FREE -> PEND -> DONE -> FREE) and retire arbiter for the L1D miss path.
// Define RVH_L1D_MSHR_RETIRE_RR_EN for round-robin retire selection; the default is lowest-index priority.
module rvh_l1d_mshr_dealloc #(
  parameter int INPUT_NUM   = 4,
  parameter int INPUT_NUM_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_vld_i,
  input  logic [INPUT_NUM_W-1:0] alloc_id_i,
  input  logic                   refill_vld_i,
  input  logic [INPUT_NUM_W-1:0] refill_id_i,
  output logic                   retire_vld_o,
  output logic [INPUT_NUM_W-1:0] retire_id_o,
  input  logic                   retire_rdy_i,
  output logic [INPUT_NUM-1:0]   mshr_bank_valid_o,
  output logic [INPUT_NUM_W:0]   done_num_o,
  output logic                   proto_err_o
);

  typedef enum logic [1:0] {
    ENT_FREE = 2'd0,
    ENT_PEND = 2'd1,
    ENT_DONE = 2'd2
  } ent_state_e;

  ent_state_e             ent_q [INPUT_NUM];
  ent_state_e             ent_d [INPUT_NUM];
  logic                   err_q, err_d;
  logic                   stall_q, stall_d;
  logic [INPUT_NUM_W-1:0] stall_id_q, stall_id_d;
`ifdef RVH_L1D_MSHR_RETIRE_RR_EN
  logic [INPUT_NUM_W-1:0] ptr_q, ptr_d;
`endif

  logic [INPUT_NUM-1:0]   done_vec_s;
  logic [INPUT_NUM_W-1:0] arb_id_s;
  logic                   arb_found_s;
  logic                   handshake_s;

  function automatic logic [INPUT_NUM_W:0] pop_count(input logic [INPUT_NUM-1:0] vec);
    logic [INPUT_NUM_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      cnt = cnt + {{INPUT_NUM_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Per-entry status vectors derived from registered state only.
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      done_vec_s[i]        = (ent_q[i] == ENT_DONE);
      mshr_bank_valid_o[i] = (ent_q[i] != ENT_FREE);
    end
    done_num_o   = pop_count(done_vec_s);
    retire_vld_o = |done_vec_s;
  end

  // Retire candidate search over DONE entries.
  always_comb begin
    arb_id_s    = '0;
    arb_found_s = 1'b0;
`ifdef RVH_L1D_MSHR_RETIRE_RR_EN
    for (int k = 0; k < INPUT_NUM; k++) begin
      logic [INPUT_NUM_W-1:0] idx;
      idx = INPUT_NUM_W'((int'(ptr_q) + k) % INPUT_NUM);
      if (!arb_found_s && done_vec_s[idx]) begin
        arb_id_s    = idx;
        arb_found_s = 1'b1;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
`else
    for (int k = 0; k < INPUT_NUM; k++) begin
      if (!arb_found_s && done_vec_s[k]) begin
        arb_id_s    = INPUT_NUM_W'(k);
        arb_found_s = 1'b1;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
`endif
  end

  // A stalled offer keeps its latched id so the consumer sees a stable request.
  always_comb begin
    if (!retire_vld_o) begin
      retire_id_o = '0;
    end else if (stall_q) begin
      retire_id_o = stall_id_q;
    end else begin
      retire_id_o = arb_id_s;
    end
    handshake_s = retire_vld_o && retire_rdy_i;
  end

  // Next-state: retire, alloc and refill are all judged against pre-edge state.
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      ent_d[i] = ent_q[i];
    end
    err_d = err_q;

    if (handshake_s) begin
      ent_d[retire_id_o] = ENT_FREE;
    end else begin
      err_d = err_d;
    end

    if (alloc_vld_i) begin
      if (ent_q[alloc_id_i] == ENT_FREE) begin
        ent_d[alloc_id_i] = ENT_PEND;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_d;
    end

    if (refill_vld_i) begin
      if (ent_q[refill_id_i] == ENT_PEND) begin
        ent_d[refill_id_i] = ENT_DONE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_d;
    end

    if (retire_vld_o && !retire_rdy_i) begin
      stall_d    = 1'b1;
      stall_id_d = retire_id_o;
    end else begin
      stall_d    = 1'b0;
      stall_id_d = '0;
    end

`ifdef RVH_L1D_MSHR_RETIRE_RR_EN
    if (handshake_s) begin
      if (retire_id_o == INPUT_NUM_W'(INPUT_NUM - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = retire_id_o + INPUT_NUM_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        ent_q[i] <= ENT_FREE;
      end
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      stall_id_q <= '0;
`ifdef RVH_L1D_MSHR_RETIRE_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        ent_q[i] <= ent_d[i];
      end
      err_q      <= err_d;
      stall_q    <= stall_d;
      stall_id_q <= stall_id_d;
`ifdef RVH_L1D_MSHR_RETIRE_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign proto_err_o = err_q;

endmodule
